// File: rtl/seq_pkg.sv
// Shared definitions for the sequence generator: program codes, FSM state
// encoding, widths, seeds and the per-step helper functions.
package seq_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned PROG_W = 3;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned STEP_W = 3;

    localparam logic [PROG_W-1:0] P_UP   = 3'd0;
    localparam logic [PROG_W-1:0] P_DOWN = 3'd1;
    localparam logic [PROG_W-1:0] P_FIB  = 3'd2;
    localparam logic [PROG_W-1:0] P_LFSR = 3'd3;
    localparam logic [PROG_W-1:0] P_GRAY = 3'd4;
    localparam logic [PROG_W-1:0] P_WALK = 3'd5;

    localparam logic [DATA_W-1:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Index of the last tick in a step period: rate code m steps every 2^m ticks.
    function automatic logic [STEP_W-1:0] rate_last(input logic [MODE_W-1:0] mode);
        case (mode)
            2'd0:    return 3'd0;
            2'd1:    return 3'd1;
            2'd2:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

    // Value shown on data_2 right after a start.
    function automatic logic [DATA_W-1:0] seed_of(input logic [PROG_W-1:0] p);
        case (p)
            P_DOWN:  return 16'hFFFF;
            P_LFSR:  return LFSR_SEED;
            P_WALK:  return 16'h0001;
            default: return 16'h0000;
        endcase
    endfunction

    // Fibonacci-form LFSR, taps 16,14,13,11, shifting right.
    function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] d);
        return {d[0] ^ d[2] ^ d[3] ^ d[5], d[15:1]};
    endfunction

    function automatic logic [DATA_W-1:0] gray_code(input logic [DATA_W-1:0] c);
        return c ^ (c >> 1);
    endfunction

endpackage

// File: rtl/tick_div.sv
// Base-rate divider: counts 0..DIV-1 while enabled and pulses tick for one
// cycle at the DIV-1 count. tick is registered (decoded one count early).
// Ports: clk, rst (async active-low), en (count enable), clr (sync clear,
// wins over en), tick (one-cycle pulse).
module tick_div #(
    parameter int unsigned DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    // Divider count and early-decoded tick register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (en) begin
            cnt  <= (cnt == CW'(DIV - 1)) ? '0 : cnt + CW'(1);
            tick <= (cnt == CW'(DIV - 2));
        end else begin
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_gen.sv
// Sequence generator feeding the eight-digit display mapper. A start pulse
// latches a program and rate code, then the selected sequence advances on
// every 2^modules-th divider tick until stopped or (Fibonacci) exhausted.
// Ports: clk; rst (async active-low); start/stop (one-cycle requests);
// prog_in/mode_in (sampled on start); prog/modules (latched program and
// rate); data_2 (current value); busy (RUN); done (DONE); err (reserved
// program requested).
module seq_gen
    import seq_pkg::*;
#(
    parameter int unsigned DIV = 100_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [PROG_W-1:0] prog_in,
    input  logic [MODE_W-1:0] mode_in,
    output logic [PROG_W-1:0] prog,
    output logic [MODE_W-1:0] modules,
    output logic [DATA_W-1:0] data_2,
    output logic              busy,
    output logic              done,
    output logic              err
);

    state_t            state, state_nxt;
    logic [PROG_W-1:0] prog_nxt;
    logic [MODE_W-1:0] modules_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              busy_nxt, done_nxt, err_nxt;
    logic [STEP_W-1:0] step_cnt, step_cnt_nxt;
    logic [DATA_W-1:0] fib_b, fib_b_nxt;
    logic              fib_ovf, fib_ovf_nxt;
    logic [DATA_W-1:0] gray_cnt, gray_cnt_nxt;

    logic              tick;
    logic              run;
    logic              load;
    logic              reject;
    logic [DATA_W:0]   fib_sum;
    logic [DATA_W-1:0] gray_inc;

    // stop masks start entirely; a start is then either accepted or rejected.
    assign run      = (state == S_RUN);
    assign load     = start && !stop && (prog_in <= P_WALK);
    assign reject   = start && !stop && (prog_in > P_WALK);
    assign fib_sum  = {1'b0, data_2} + {1'b0, fib_b};
    assign gray_inc = gray_cnt + DATA_W'(1);

    tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .clr  (load),
        .tick (tick)
    );

    // Next-state and next-output decode.
    always_comb begin
        state_nxt    = state;
        prog_nxt     = prog;
        modules_nxt  = modules;
        data_nxt     = data_2;
        err_nxt      = err;
        step_cnt_nxt = step_cnt;
        fib_b_nxt    = fib_b;
        fib_ovf_nxt  = fib_ovf;
        gray_cnt_nxt = gray_cnt;

        if (stop) begin
            if (run) state_nxt = S_IDLE;
        end else if (load) begin
            state_nxt    = S_RUN;
            prog_nxt     = prog_in;
            modules_nxt  = mode_in;
            data_nxt     = seed_of(prog_in);
            err_nxt      = 1'b0;
            step_cnt_nxt = '0;
            fib_b_nxt    = DATA_W'(1);
            fib_ovf_nxt  = 1'b0;
            gray_cnt_nxt = '0;
        end else if (reject) begin
            state_nxt = S_IDLE;
            err_nxt   = 1'b1;
        end else if (run && tick) begin
            step_cnt_nxt = step_cnt + STEP_W'(1);
            if (step_cnt == rate_last(modules)) begin
                step_cnt_nxt = '0;
                case (prog)
                    P_UP:   data_nxt = data_2 + DATA_W'(1);
                    P_DOWN: data_nxt = data_2 - DATA_W'(1);
                    P_FIB: begin
                        // An overflowing b is still exposed once; the attempt
                        // after that ends the run on the last valid value.
                        if (fib_ovf) begin
                            state_nxt = S_DONE;
                        end else begin
                            data_nxt    = fib_b;
                            fib_b_nxt   = fib_sum[DATA_W-1:0];
                            fib_ovf_nxt = fib_sum[DATA_W];
                        end
                    end
                    P_LFSR: data_nxt = lfsr_next(data_2);
                    P_GRAY: begin
                        gray_cnt_nxt = gray_inc;
                        data_nxt     = gray_code(gray_inc);
                    end
                    P_WALK:  data_nxt = {data_2[DATA_W-2:0], data_2[DATA_W-1]};
                    default: data_nxt = data_2;
                endcase
            end
        end

        busy_nxt = (state_nxt == S_RUN);
        done_nxt = (state_nxt == S_DONE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            prog     <= '0;
            modules  <= '0;
            data_2   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            step_cnt <= '0;
            fib_b    <= '0;
            fib_ovf  <= 1'b0;
            gray_cnt <= '0;
        end else begin
            state    <= state_nxt;
            prog     <= prog_nxt;
            modules  <= modules_nxt;
            data_2   <= data_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            err      <= err_nxt;
            step_cnt <= step_cnt_nxt;
            fib_b    <= fib_b_nxt;
            fib_ovf  <= fib_ovf_nxt;
            gray_cnt <= gray_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen. Two instances share all inputs: dut (DIV=4)
// and dut_b (DIV=2). Inputs change and outputs are sampled on the falling
// edge, so after start() returns the seed is already on data_2.
module tb_seq_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic [2:0]  prog_in;
    logic [1:0]  mode_in;

    logic [2:0]  prog,    prog_b;
    logic [1:0]  modules, modules_b;
    logic [15:0] data_2,  data_b;
    logic        busy,    busy_b;
    logic        done,    done_b;
    logic        err,     err_b;

    int n_vec = 0;
    int n_bad = 0;

    seq_gen #(.DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .prog_in (prog_in),
        .mode_in (mode_in),
        .prog    (prog),
        .modules (modules),
        .data_2  (data_2),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    seq_gen #(.DIV(2)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .prog_in (prog_in),
        .mode_in (mode_in),
        .prog    (prog_b),
        .modules (modules_b),
        .data_2  (data_b),
        .busy    (busy_b),
        .done    (done_b),
        .err     (err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h, want 0x%04h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [2:0] p, input logic [1:0] m);
        start   = 1'b1;
        prog_in = p;
        mode_in = m;
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
    endtask

    logic [15:0] fa, fb, ft;

    initial begin
        clk     = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        prog_in = 3'd0;
        mode_in = 2'd0;
        #1 rst  = 1'b0;
        cyc(2);

        // Reset state
        chk("rst_prog",    16'(prog),    16'h0);
        chk("rst_modules", 16'(modules), 16'h0);
        chk("rst_data",    data_2,       16'h0000);
        chk("rst_busy",    16'(busy),    16'h0);
        chk("rst_done",    16'(done),    16'h0);
        chk("rst_err",     16'(err),     16'h0);
        rst = 1'b1;
        cyc(2);

        // Up counter, DIV=4, rate 0: steps every 4 cycles
        pulse_start(3'd0, 2'd0);
        chk("up_seed", data_2, 16'h0000);
        chk("up_busy", 16'(busy), 16'h1);
        cyc(3);
        chk("up_pre_step", data_2, 16'h0000);
        cyc(1);
        chk("up_step1", data_2, 16'h0001);
        cyc(4);
        chk("up_step2", data_2, 16'h0002);
        cyc(4);
        chk("up_step3", data_2, 16'h0003);
        // Preset 0xFFFF across a non-step edge, then let the next step wrap
        force dut.data_2 = 16'hFFFF;
        cyc(1);
        release dut.data_2;
        chk("up_preset", data_2, 16'hFFFF);
        cyc(2);
        chk("up_preset_hold", data_2, 16'hFFFF);
        cyc(1);
        chk("up_wrap", data_2, 16'h0000);

        // Down counter, rate 2: first step 16 cycles after the seed
        pulse_start(3'd1, 2'd2);
        chk("dn_seed", data_2, 16'hFFFF);
        chk("dn_prog", 16'(prog), 16'h1);
        chk("dn_modules", 16'(modules), 16'h2);
        cyc(15);
        chk("dn_pre_step", data_2, 16'hFFFF);
        cyc(1);
        chk("dn_step1", data_2, 16'hFFFE);

        // Fibonacci on the DIV=2 instance
        pulse_start(3'd2, 2'd0);
        chk("fib_seed", data_b, 16'h0000);
        chk("fib_prog", 16'(prog_b), 16'h2);
        cyc(2); chk("fib_s1", data_b, 16'd1);
        cyc(2); chk("fib_s2", data_b, 16'd1);
        cyc(2); chk("fib_s3", data_b, 16'd2);
        cyc(2); chk("fib_s4", data_b, 16'd3);
        cyc(2); chk("fib_s5", data_b, 16'd5);
        cyc(2); chk("fib_s6", data_b, 16'd8);
        fa = 16'd8;
        fb = 16'd13;
        for (int i = 7; i <= 24; i++) begin
            cyc(2);
            chk("fib_seq", data_b, fa + 16'd0 == fa ? fb : fb);
            ft = fa + fb;
            fa = fb;
            fb = ft;
        end
        chk("fib_last", data_b, 16'hB520);
        cyc(1);
        chk("fib_pre_done", 16'(done_b), 16'h0);
        cyc(1);
        chk("fib_done", 16'(done_b), 16'h1);
        chk("fib_done_busy", 16'(busy_b), 16'h0);
        chk("fib_done_data", data_b, 16'hB520);
        cyc(6);
        chk("fib_done_hold", data_b, 16'hB520);

        // LFSR, also restarting dut_b out of DONE
        pulse_start(3'd3, 2'd0);
        chk("lfsr_seed", data_2, 16'hACE1);
        chk("lfsr_restart_done", 16'(done_b), 16'h0);
        chk("lfsr_restart_busy", 16'(busy_b), 16'h1);
        cyc(4);
        chk("lfsr_step1", data_2, 16'h5670);
        cyc(4);
        chk("lfsr_step2", data_2, 16'hAB38);

        // Gray, then a lone stop
        pulse_start(3'd4, 2'd0);
        chk("gray_seed", data_2, 16'h0000);
        cyc(8);
        chk("gray_step2", data_2, 16'h0003);
        cyc(4);
        chk("gray_step3", data_2, 16'h0002);
        pulse_stop();
        chk("stop_busy", 16'(busy), 16'h0);
        chk("stop_data", data_2, 16'h0002);
        cyc(8);
        chk("stop_hold", data_2, 16'h0002);

        // Walking one on DIV=2, rate 1: a step every 4 cycles
        pulse_start(3'd5, 2'd1);
        chk("walk_seed", data_b, 16'h0001);
        chk("walk_modules", 16'(modules_b), 16'h1);
        cyc(4);
        chk("walk_step1", data_b, 16'h0002);
        cyc(56);
        chk("walk_step15", data_b, 16'h8000);
        cyc(4);
        chk("walk_wrap", data_b, 16'h0001);

        // start and stop together during RUN: stop only
        pulse_start(3'd0, 2'd0);
        cyc(8);
        chk("ss_pre", data_2, 16'h0002);
        start   = 1'b1;
        stop    = 1'b1;
        prog_in = 3'd5;
        mode_in = 2'd3;
        @(negedge clk);
        start   = 1'b0;
        stop    = 1'b0;
        chk("ss_busy", 16'(busy), 16'h0);
        chk("ss_data", data_2, 16'h0002);
        chk("ss_data_b", data_b, 16'h0004);
        chk("ss_prog", 16'(prog), 16'h0);
        chk("ss_modules", 16'(modules), 16'h0);
        cyc(8);
        chk("ss_hold", data_2, 16'h0002);

        // Reserved program: err, nothing else moves
        pulse_start(3'd7, 2'd2);
        chk("err_flag", 16'(err), 16'h1);
        chk("err_flag_b", 16'(err_b), 16'h1);
        chk("err_prog", 16'(prog), 16'h0);
        chk("err_modules", 16'(modules), 16'h0);
        chk("err_data", data_2, 16'h0002);
        chk("err_busy", 16'(busy), 16'h0);

        // Valid start clears err
        pulse_start(3'd3, 2'd3);
        chk("clr_err", 16'(err), 16'h0);
        chk("clr_busy", 16'(busy), 16'h1);
        chk("clr_prog", 16'(prog), 16'h3);
        chk("clr_data", data_2, 16'hACE1);
        cyc(5);

        // Asynchronous reset between edges
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_prog",    16'(prog),    16'h0);
        chk("arst_modules", 16'(modules), 16'h0);
        chk("arst_data",    data_2,       16'h0000);
        chk("arst_busy",    16'(busy),    16'h0);
        chk("arst_done",    16'(done),    16'h0);
        chk("arst_err",     16'(err),     16'h0);
        @(negedge clk);
        rst = 1'b1;
        cyc(40);
        chk("post_rst_busy", 16'(busy), 16'h0);
        chk("post_rst_data", data_2, 16'h0000);
        chk("post_rst_data_b", data_b, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
